// File: rtl/uart_tx_queue.sv
`default_nettype none
// ============================================================================
// uart_tx_queue : byte FIFO feeding an 8N1 UART transmitter (LSB first)
// Revision      : 1.0
// ============================================================================
module uart_tx_queue #(
   parameter int DEPTH        = 8,
   parameter int CLKS_PER_BIT = 16
) (
   input  logic                     clk,
   input  logic                     rst,
   input  logic                     valid,
   output logic                     ready,
   input  logic [7:0]               data,
   output logic                     uart_tx,
   output logic                     busy,
   output logic [$clog2(DEPTH):0]   count
);

   localparam int c_aw = $clog2(DEPTH);
   localparam int c_bw = $clog2(CLKS_PER_BIT);
   localparam logic [c_bw-1:0] c_baud_last = c_bw'(CLKS_PER_BIT - 1);
   localparam logic [c_aw:0]   c_full      = (c_aw+1)'(DEPTH);

   typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_t;

   state_t            r_state;
   state_t            w_state_next;
   logic [7:0]        r_mem [DEPTH];
   logic [c_aw-1:0]   r_wr_ptr;
   logic [c_aw-1:0]   r_rd_ptr;
   logic [c_aw:0]     r_count;
   logic [c_bw-1:0]   r_baud;
   logic [c_bw-1:0]   w_baud_next;
   logic [2:0]        r_bit_idx;
   logic [2:0]        w_idx_next;
   logic [7:0]        r_shift;
   logic [7:0]        w_shift_next;
   logic              r_tx;
   logic              w_tx_next;
   logic              w_push;
   logic              w_pop;
   logic              w_baud_term;

   assign ready       = (r_count != c_full);
   assign w_push      = valid && ready;
   assign w_baud_term = (r_baud == c_baud_last);
   assign uart_tx     = r_tx;
   assign busy        = (r_state != IDLE) || (r_count != '0);
   assign count       = r_count;

   // Storage is never reset; entries are only read while count > 0.
   always_ff @(posedge clk) begin
      if (w_push) begin
         r_mem[r_wr_ptr] <= data;
      end
   end

   always_comb begin
      w_state_next = r_state;
      w_baud_next  = r_baud;
      w_idx_next   = r_bit_idx;
      w_shift_next = r_shift;
      w_pop        = 1'b0;
      w_tx_next    = 1'b1;
      if (r_state != IDLE) begin
         w_baud_next = w_baud_term ? '0 : r_baud + 1'b1;
      end
      case (r_state)
         IDLE: begin
            if (r_count != '0) begin
               w_pop        = 1'b1;
               w_state_next = START;
               w_shift_next = r_mem[r_rd_ptr];
               w_baud_next  = '0;
            end
         end
         START: begin
            if (w_baud_term) begin
               w_state_next = DATA;
               w_idx_next   = 3'd0;
            end
         end
         DATA: begin
            if (w_baud_term) begin
               w_shift_next = {1'b0, r_shift[7:1]};
               w_idx_next   = r_bit_idx + 3'd1;
               if (r_bit_idx == 3'd7) begin
                  w_state_next = STOP;
               end
            end
         end
         STOP: begin
            if (w_baud_term) begin
               // Chain straight into the next frame when more bytes wait.
               if (r_count != '0) begin
                  w_pop        = 1'b1;
                  w_state_next = START;
                  w_shift_next = r_mem[r_rd_ptr];
               end else begin
                  w_state_next = IDLE;
               end
            end
         end
         default: w_state_next = IDLE;
      endcase
      case (w_state_next)
         START:   w_tx_next = 1'b0;
         DATA:    w_tx_next = w_shift_next[0];
         default: w_tx_next = 1'b1;
      endcase
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         r_state   <= IDLE;
         r_wr_ptr  <= '0;
         r_rd_ptr  <= '0;
         r_count   <= '0;
         r_baud    <= '0;
         r_bit_idx <= '0;
         r_shift   <= '0;
         r_tx      <= 1'b1;
      end else begin
         r_state   <= w_state_next;
         r_baud    <= w_baud_next;
         r_bit_idx <= w_idx_next;
         r_shift   <= w_shift_next;
         r_tx      <= w_tx_next;
         if (w_push) begin
            r_wr_ptr <= r_wr_ptr + 1'b1;
         end
         if (w_pop) begin
            r_rd_ptr <= r_rd_ptr + 1'b1;
         end
         if (w_push && !w_pop) begin
            r_count <= r_count + 1'b1;
         end else if (w_pop && !w_push) begin
            r_count <= r_count - 1'b1;
         end
      end
   end

endmodule
`default_nettype wire

// File: tb/tb_uart_tx_queue.sv
`default_nettype none
// ============================================================================
// tb_uart_tx_queue : directed bench for uart_tx_queue (DEPTH=4, CLKS_PER_BIT=4)
// Revision         : 1.0
// ============================================================================
module tb_uart_tx_queue;

   localparam int DEPTH = 4;
   localparam int CPB   = 4;

   logic       clk = 1'b0;
   logic       rst;
   logic       valid;
   logic       ready;
   logic [7:0] data;
   logic       uart_tx;
   logic       busy;
   logic [2:0] count;

   always #5 clk = ~clk;

   uart_tx_queue #(.DEPTH(DEPTH), .CLKS_PER_BIT(CPB)) dut (
      .clk     (clk),
      .rst     (rst),
      .valid   (valid),
      .ready   (ready),
      .data    (data),
      .uart_tx (uart_tx),
      .busy    (busy),
      .count   (count)
   );

   int n_cmp = 0;
   int n_err = 0;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s actual=%0h required=%0h", name, act, exp);
      end
   endtask

   // Serial line decoder: frames are discarded if reset fell while they were in flight.
   logic [7:0] rx_q[$];
   logic       stop_q[$];
   int         start_q[$];
   int         cyc = 0;
   int         rst_cnt = 0;

   always @(posedge clk) cyc <= cyc + 1;
   always @(negedge rst) rst_cnt <= rst_cnt + 1;

   always begin : mon
      logic [7:0] b;
      int         r0;
      int         t0;
      @(negedge clk);
      if (rst === 1'b1 && uart_tx === 1'b0) begin
         r0 = rst_cnt;
         t0 = cyc;
         repeat (CPB/2) @(negedge clk);
         for (int i = 0; i < 8; i++) begin
            repeat (CPB) @(negedge clk);
            b[i] = uart_tx;
         end
         repeat (CPB) @(negedge clk);
         if (rst_cnt == r0) begin
            rx_q.push_back(b);
            stop_q.push_back(uart_tx);
            start_q.push_back(t0);
         end
      end
   end

   logic [7:0] exp_q[$];
   int         rx_base = 0;

   task automatic check_rx(input string name);
      chk({name, "_frames"}, rx_q.size() - rx_base, exp_q.size());
      for (int i = 0; i < exp_q.size() && rx_base + i < rx_q.size(); i++) begin
         chk($sformatf("%s_byte%0d", name, i), rx_q[rx_base+i], exp_q[i]);
         chk($sformatf("%s_stop%0d", name, i), stop_q[rx_base+i], 1);
      end
      rx_base = rx_q.size();
      exp_q.delete();
   endtask

   task automatic wait_idle(input string name);
      int n = 0;
      while (busy !== 1'b0 && n < 1000) begin
         @(negedge clk);
         n++;
      end
      chk({name, "_idle"}, busy, 0);
      repeat (2) @(negedge clk);
   endtask

   task automatic push_wait(input logic [7:0] b);
      int n = 0;
      while (ready !== 1'b1 && n < 500) begin
         @(negedge clk);
         n++;
      end
      chk("push_ready", ready, 1);
      valid = 1'b1;
      data  = b;
      @(negedge clk);
      valid = 1'b0;
   endtask

   typedef struct {
      logic [7:0] data;
      logic [9:0] frame;   // bit i = line level during serial bit slot i
   } vec_t;

   vec_t vecs[5];
   int   low_cnt;

   initial begin
      vecs[0] = '{8'hA5, 10'b1101001010};
      vecs[1] = '{8'h00, 10'b1000000000};
      vecs[2] = '{8'hFF, 10'b1111111110};
      vecs[3] = '{8'h3C, 10'b1001111000};
      vecs[4] = '{8'h81, 10'b1100000010};

      rst   = 1'b1;
      valid = 1'b0;
      data  = 8'h00;
      #1 rst = 1'b0;
      #1;
      chk("reset_tx", uart_tx, 1);
      chk("reset_busy", busy, 0);
      chk("reset_count", count, 0);
      chk("reset_ready", ready, 1);
      repeat (2) @(negedge clk);
      rst = 1'b1;
      @(negedge clk);

      // Single frames, cycle by cycle
      for (int v = 0; v < 5; v++) begin
         valid = 1'b1;
         data  = vecs[v].data;
         @(negedge clk);
         valid = 1'b0;
         chk("queued_count", count, 1);
         chk("prepop_tx", uart_tx, 1);
         for (int c = 0; c < 10*CPB; c++) begin
            @(negedge clk);
            chk($sformatf("frame_%02h_cyc%0d", vecs[v].data, c), uart_tx, vecs[v].frame[c/CPB]);
            if (c == 0) chk("popped_count", count, 0);
         end
         chk("busy_last_stop", busy, 1);
         @(negedge clk);
         chk("busy_fall", busy, 0);
         chk("idle_tx", uart_tx, 1);
         repeat (2) @(negedge clk);
         exp_q.push_back(vecs[v].data);
         check_rx($sformatf("single_%02h", vecs[v].data));
      end

      // Fill to full, extra pushes ignored until first pop
      for (int i = 0; i < 5; i++) begin
         valid = 1'b1;
         data  = 8'(i + 1);
         @(negedge clk);
      end
      chk("full_count", count, 4);
      chk("full_ready", ready, 0);
      data = 8'h66;
      for (int k = 0; k < 36; k++) begin
         @(negedge clk);
         chk($sformatf("full_hold_%0d", k), count, 4);
      end
      valid = 1'b0;
      @(negedge clk);
      chk("first_pop_count", count, 3);
      chk("first_pop_ready", ready, 1);
      wait_idle("fill");
      exp_q = {8'h01, 8'h02, 8'h03, 8'h04, 8'h05};
      check_rx("fill");

      // Back-to-back frames
      valid = 1'b1;
      data  = 8'h55;
      @(negedge clk);
      data  = 8'hAA;
      @(negedge clk);
      valid = 1'b0;
      chk("b2b_count", count, 1);
      repeat (79) @(negedge clk);
      chk("b2b_busy_end", busy, 1);
      @(negedge clk);
      chk("b2b_busy_fall", busy, 0);
      repeat (2) @(negedge clk);
      chk("b2b_gap", (start_q.size() >= rx_base + 2) ?
          start_q[rx_base+1] - start_q[rx_base] : -1, 40);
      exp_q = {8'h55, 8'hAA};
      check_rx("b2b");

      // Push on the same edge as the STOP-terminal pop
      valid = 1'b1;
      data  = 8'h11;
      @(negedge clk);
      data  = 8'h22;
      @(negedge clk);
      valid = 1'b0;
      chk("pdp_count_early", count, 1);
      repeat (39) @(negedge clk);
      chk("pdp_count_stop", count, 1);
      chk("pdp_tx_stop", uart_tx, 1);
      valid = 1'b1;
      data  = 8'h3C;
      @(negedge clk);
      valid = 1'b0;
      chk("pdp_count", count, 1);
      chk("pdp_tx_start", uart_tx, 0);
      wait_idle("pdp");
      exp_q = {8'h11, 8'h22, 8'h3C};
      check_rx("pdp");

      // Pointer wrap
      for (int i = 0; i < 10; i++) push_wait(8'(8'h10 + i));
      wait_idle("wrap");
      for (int i = 0; i < 10; i++) exp_q.push_back(8'(8'h10 + i));
      check_rx("wrap");

      // Mid-frame reset during DATA bit 3 of 0x0F
      valid = 1'b1;
      data  = 8'h0F;
      @(negedge clk);
      data  = 8'h77;
      @(negedge clk);
      data  = 8'h88;
      @(negedge clk);
      valid = 1'b0;
      chk("mfr_count", count, 2);
      repeat (17) @(negedge clk);
      chk("mfr_busy_before", busy, 1);
      #1 rst = 1'b0;
      #1;
      chk("mfr_tx", uart_tx, 1);
      chk("mfr_count_rst", count, 0);
      chk("mfr_busy", busy, 0);
      chk("mfr_ready", ready, 1);
      @(negedge clk);
      rst = 1'b1;
      low_cnt = 0;
      for (int k = 0; k < 60; k++) begin
         @(negedge clk);
         if (uart_tx !== 1'b1) low_cnt++;
      end
      chk("mfr_line_low_cycles", low_cnt, 0);
      chk("mfr_busy_after", busy, 0);
      check_rx("mfr");

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
`default_nettype wire

// File: doc/uart_tx_queue.md
UART_TX_QUEUE -- requirements
Module: uart_tx_queue

Interface
REQ-001 Parameter DEPTH, default 8, sets the FIFO entry count; it SHALL be a power of two and at least 2.
REQ-002 Parameter CLKS_PER_BIT, default 16, sets the clk cycles per serial bit; it SHALL be at least 2.
REQ-003 Port clk, input, 1 bit: single clock; all state SHALL update on the rising edge.
REQ-004 Port rst, input, 1 bit: reset, asynchronous and active-low.
REQ-005 Port valid, input, 1 bit: the memory stage offers a byte on data.
REQ-006 Port ready, output, 1 bit: the queue can accept a byte this cycle.
REQ-007 Port data, input, 8 bits: byte to transmit.
REQ-008 Port uart_tx, output, 1 bit: serial line, 8N1, idle high.
REQ-009 Port busy, output, 1 bit: high when a frame is in flight or the FIFO is non-empty.
REQ-010 Port count, output, $clog2(DEPTH)+1 bits: current FIFO occupancy.

Function
REQ-011 ready SHALL equal (count != DEPTH); it is combinational from registered state only and SHALL NOT depend on valid.
REQ-012 A push SHALL occur on a rising edge where valid && ready; data is written at the write pointer and the write pointer increments modulo DEPTH.
REQ-013 valid while ready is low SHALL be ignored: no write, no pointer change, no count change.
REQ-014 The FSM SHALL have four states: IDLE, START, DATA, STOP.
REQ-015 In IDLE with count > 0, the queue SHALL pop the head into an 8-bit shift register, clear the baud counter, and enter START on the same edge.
REQ-016 The baud counter SHALL count 0..CLKS_PER_BIT-1; each state holds its bit for exactly CLKS_PER_BIT cycles.
REQ-017 In START, uart_tx SHALL be 0; at the terminal baud count, the FSM enters DATA with the bit index at 0.
REQ-018 In DATA, uart_tx SHALL be shift[0], giving LSB first; at each terminal count the register shifts right and the index increments; after index 7 the FSM enters STOP.
REQ-019 In STOP, uart_tx SHALL be 1; at the terminal count, if count > 0 the FSM pops and enters START directly (back-to-back frames with no idle gap), otherwise it enters IDLE.
REQ-020 In IDLE, uart_tx SHALL be 1.
REQ-021 uart_tx SHALL be driven from a register, so it is glitch-free.
REQ-022 A frame SHALL last exactly 10*CLKS_PER_BIT cycles.
REQ-023 A byte pushed into an empty queue while IDLE at edge N SHALL be popped at edge N+1, and uart_tx SHALL fall after edge N+1.
REQ-024 A simultaneous push and pop on one edge SHALL leave count unchanged and preserve FIFO order.
REQ-025 When full, ready SHALL be low; a pop on edge N SHALL raise ready for the cycle after edge N.
REQ-026 Read and write pointers SHALL wrap modulo DEPTH; FIFO order SHALL be strictly preserved across the wrap.
REQ-027 count SHALL never exceed DEPTH and never underflow; a pop SHALL occur only when count > 0.
REQ-028 busy SHALL equal (state != IDLE) || (count != 0).

Reset
REQ-029 While rst = 0, the block SHALL immediately (asynchronously) set: state IDLE, pointers 0, count 0, baud counter 0, bit index 0, shift register 0, uart_tx 1, busy 0.
REQ-030 After reset, ready SHALL be 1.
REQ-031 Reset asserted mid-frame SHALL abort the frame, drive uart_tx high immediately, and discard all FIFO contents.
REQ-032 FIFO storage SHALL need no reset; its contents are unobservable while count = 0.

Verification (DEPTH=4, CLKS_PER_BIT=4)
REQ-033 Single byte: push 0xA5 -> after a 1-cycle pop latency, uart_tx shows 0 (4 cycles), then bits 1,0,1,0,0,1,0,1 (4 cycles each), then 1 (4 cycles), then stays high; busy falls 40 cycles after the pop edge.
REQ-034 Fill/full: push 0x01,0x02,0x03,0x04,0x05 on consecutive cycles -> the first byte pops and is transmitted; 0x02..0x05 fill the FIFO; ready drops once count = 4; any further push is ignored and count stays at 4 until the first pop at the STOP of 0x01.
REQ-035 Back-to-back: push 0x55 then 0xAA -> two frames totalling 80 cycles, STOP of frame 1 immediately followed by START of frame 2, no idle-high gap beyond the 4-cycle stop bit.
REQ-036 Push during pop: with count = 1 and FSM at STOP's terminal count, push 0x3C on that same edge -> count stays 1 and 0x3C is sent after the popped byte.
REQ-037 Wrap: push and transmit 10 bytes 0x10..0x19 -> the decoded serial stream equals the push order exactly, with the pointers having wrapped twice.
REQ-038 Mid-frame reset: pull rst low during the DATA bit 3 of 0x0F with 2 bytes queued -> uart_tx = 1, count = 0, busy = 0 immediately; after release the line stays high with no further frames.
